dac_write_scheduler: RTL and testbench

Shares the single serial threshold DAC on the NIM+ board between N_CH independent requesters (per-input threshold registers, bulk-load engine, calibration) and sequences each write as one 16-bit SPI-style frame on DAC_SER_CLK / DAC_NSYNC / DAC_DIN. It sits in the NIMPlus logic between the parameter-derived DAC requests and the DAC output pins. Arbitration is round-robin with one frame in flight at a time, and every accepted request is acknowledged with a single pulse.

---
 rtl/dac_write_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_dac_write_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_scheduler.sv
// Round-robin scheduler sharing one serial threshold DAC between N_CH requesters.
// Each grant is shifted out as a 16-bit frame {channel[3:0], code[11:0]}, MSB first.
module dac_write_scheduler #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned SCLK_DIV   = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*12-1:0]   req_data,
  output logic [N_CH-1:0]      ack,
  output logic                 busy,
  output logic                 DAC_SER_CLK,
  output logic                 DAC_NSYNC,
  output logic                 DAC_DIN
);

  localparam int unsigned IW     = 4;
  localparam int unsigned CODE_W = 12;
  localparam int unsigned FW     = 16;
  localparam int unsigned DW     = $clog2(SCLK_DIV + 1);
  localparam int unsigned GW     = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, GAP} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt, div_cnt_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic              phase_hi, phase_hi_nxt;
  logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [IW-1:0]     gnt_idx, gnt_idx_nxt;
  logic [FW-1:0]     frame, frame_nxt;
  logic              run;

  logic [N_CH-1:0]   ack_nxt;
  logic              busy_nxt, sclk_nxt, nsync_nxt, din_nxt;

  logic              hit_hi, hit_lo;
  logic [IW-1:0]     idx_hi, idx_lo, gnt_sel;
  logic [CODE_W-1:0] sel_data;

  // Round-robin pick: lowest request at or above ptr, else lowest overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (req[j] && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = IW'(j);
      end
      if (req[j] && (IW'(j) >= ptr) && !hit_hi) begin
        hit_hi = 1'b1;
        idx_hi = IW'(j);
      end
    end
    gnt_sel = hit_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (IW'(j) == gnt_sel) sel_data = req_data[CODE_W*j +: CODE_W];
    end
  end

  // Reset release synchroniser: grants are allowed from the 2nd edge onwards.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) run <= 1'b0;
    else          run <= 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      phase_hi <= 1'b0;
      gap_cnt  <= '0;
      ptr      <= '0;
      gnt_idx  <= '0;
      frame    <= '0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      phase_hi <= phase_hi_nxt;
      gap_cnt  <= gap_cnt_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= gnt_idx_nxt;
      frame    <= frame_nxt;
    end
  end

  // Next state plus pin values for the current state; pins are registered below.
  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    bit_cnt_nxt  = bit_cnt;
    phase_hi_nxt = phase_hi;
    gap_cnt_nxt  = gap_cnt;
    ptr_nxt      = ptr;
    gnt_idx_nxt  = gnt_idx;
    frame_nxt    = frame;
    ack_nxt      = '0;
    busy_nxt     = 1'b0;
    sclk_nxt     = 1'b1;
    nsync_nxt    = 1'b1;
    din_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (run && (|req)) begin
          state_nxt   = SYNC;
          gnt_idx_nxt = gnt_sel;
          frame_nxt   = {gnt_sel, sel_data};
          ptr_nxt     = (gnt_sel == IW'(N_CH - 1)) ? '0 : gnt_sel + IW'(1);
          div_cnt_nxt = DW'(SCLK_DIV - 1);
        end
      end
      SYNC: begin
        busy_nxt  = 1'b1;
        nsync_nxt = 1'b0;
        din_nxt   = frame[FW-1];
        if (div_cnt == '0) begin
          state_nxt    = SHIFT;
          bit_cnt_nxt  = 4'd15;
          phase_hi_nxt = 1'b0;
          div_cnt_nxt  = DW'(SCLK_DIV - 1);
        end else begin
          div_cnt_nxt = div_cnt - DW'(1);
        end
      end
      SHIFT: begin
        busy_nxt  = 1'b1;
        nsync_nxt = 1'b0;
        sclk_nxt  = phase_hi;
        din_nxt   = frame[bit_cnt];
        if (div_cnt == '0) begin
          div_cnt_nxt = DW'(SCLK_DIV - 1);
          if (phase_hi) begin
            phase_hi_nxt = 1'b0;
          end else if (bit_cnt == 4'd0) begin
            state_nxt   = GAP;
            gap_cnt_nxt = GW'(GAP_CYCLES - 1);
          end else begin
            // Next bit is presented together with the rising SCLK.
            phase_hi_nxt = 1'b1;
            bit_cnt_nxt  = bit_cnt - 4'd1;
          end
        end else begin
          div_cnt_nxt = div_cnt - DW'(1);
        end
      end
      GAP: begin
        busy_nxt = 1'b1;
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          for (int unsigned j = 0; j < N_CH; j++) ack_nxt[j] = (IW'(j) == gnt_idx);
        end
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_cnt_nxt = gap_cnt - GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ack         <= '0;
      busy        <= 1'b0;
      DAC_SER_CLK <= 1'b1;
      DAC_NSYNC   <= 1'b1;
      DAC_DIN     <= 1'b0;
    end else begin
      ack         <= ack_nxt;
      busy        <= busy_nxt;
      DAC_SER_CLK <= sclk_nxt;
      DAC_NSYNC   <= nsync_nxt;
      DAC_DIN     <= din_nxt;
    end
  end

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Bench for dac_write_scheduler: a frame monitor decodes the DAC pins and
// compares each frame against a queue of expected words.
module tb_dac_write_scheduler;

  localparam int unsigned N_CH = 8;
  localparam int unsigned DIV  = 2;
  localparam int unsigned GAP  = 4;
  localparam int unsigned NB   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                aresetn;
  logic [N_CH-1:0]     req;
  logic [N_CH*12-1:0]  req_data;
  logic [N_CH-1:0]     ack;
  logic                busy, sclk, nsync, din;

  logic [NB-1:0]       req_b;
  logic [NB*12-1:0]    req_data_b;
  logic [NB-1:0]       ack_b;
  logic                busy_b, sclk_b, nsync_b, din_b;

  dac_write_scheduler #(.N_CH(N_CH), .SCLK_DIV(DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .aresetn(aresetn), .req(req), .req_data(req_data), .ack(ack),
    .busy(busy), .DAC_SER_CLK(sclk), .DAC_NSYNC(nsync), .DAC_DIN(din));

  dac_write_scheduler #(.N_CH(NB), .SCLK_DIV(1), .GAP_CYCLES(1)) dut_min (
    .clk(clk), .aresetn(aresetn), .req(req_b), .req_data(req_data_b), .ack(ack_b),
    .busy(busy_b), .DAC_SER_CLK(sclk_b), .DAC_NSYNC(nsync_b), .DAC_DIN(din_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  // Frame monitor for the main instance, sampled on the falling clk edge.
  int          cyc = 0, last_fall = 0, last_period = 0, first_dly = 0;
  int          bits = 0, low_cnt = 0, frames = 0, ack_total = 0;
  logic        prev_sclk = 1'b1, prev_nsync = 1'b1, in_frame = 1'b0, fall_valid = 1'b0;
  logic [15:0] word = '0, exp_w;

  always @(negedge clk) begin
    if (!aresetn) begin
      in_frame   = 1'b0;
      fall_valid = 1'b0;
      bits       = 0;
    end else begin
      if (prev_nsync && !nsync) begin
        if (fall_valid) last_period = cyc - last_fall;
        last_fall  = cyc;
        fall_valid = 1'b1;
        in_frame   = 1'b1;
        bits       = 0;
        word       = '0;
        low_cnt    = 0;
      end
      if (!nsync) low_cnt++;
      if (prev_sclk && !sclk && !nsync) begin
        if (bits == 0) first_dly = cyc - last_fall;
        word = {word[14:0], din};
        bits++;
      end
      if (ack != '0) ack_total += $countones(ack);
      if (!prev_nsync && nsync && in_frame) begin
        chk("queue_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("frame_word", word, exp_w);
          chk("frame_bits", bits, 16);
          chk("frame_ack", ack, 32'(1 << exp_w[15:12]));
          chk("nsync_low_len", low_cnt, 32 * DIV);
          chk("first_sclk_fall", first_dly, DIV);
        end
        in_frame = 1'b0;
        frames++;
      end
    end
    prev_sclk  = sclk;
    prev_nsync = nsync;
    cyc++;
  end

  // Lighter monitor for the minimum-configuration instance.
  int          last_fall_b = 0, period_b = 0, low_b = 0, last_low_b = 0, frames_b = 0;
  logic        prev_sclk_b = 1'b1, prev_nsync_b = 1'b1, fall_valid_b = 1'b0;
  logic [15:0] word_b = '0, last_word_b = '0;
  logic [NB-1:0] last_ack_b = '0;

  always @(negedge clk) begin
    if (!aresetn) begin
      fall_valid_b = 1'b0;
    end else begin
      if (prev_nsync_b && !nsync_b) begin
        if (fall_valid_b) period_b = cyc - last_fall_b;
        last_fall_b  = cyc;
        fall_valid_b = 1'b1;
        low_b        = 0;
        word_b       = '0;
      end
      if (!nsync_b) low_b++;
      if (prev_sclk_b && !sclk_b && !nsync_b) word_b = {word_b[14:0], din_b};
      if (!prev_nsync_b && nsync_b) begin
        last_word_b = word_b;
        last_ack_b  = ack_b;
        last_low_b  = low_b;
        frames_b++;
      end
    end
    prev_sclk_b  = sclk_b;
    prev_nsync_b = nsync_b;
  end

  task automatic wait_ack(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[c] && n < 400);
    chk($sformatf("ack_wait_ch%0d", c), 32'(ack[c]), 1);
    req[c] = 1'b0;
  endtask

  typedef struct {
    int          ch;
    logic [11:0] data;
    logic [15:0] word;
  } vec_t;

  vec_t        vecs[4];
  logic [11:0] d8[N_CH];
  int          base, n, acks_before;

  initial begin
    vecs[0] = '{3, 12'hABC, 16'h3ABC};
    vecs[1] = '{0, 12'h000, 16'h0000};
    vecs[2] = '{5, 12'h5A5, 16'h55A5};
    vecs[3] = '{7, 12'hFFF, 16'h7FFF};

    aresetn = 1'b0; req = '0; req_data = '0; req_b = '0; req_data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_nsync", nsync, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_min_nsync", nsync_b, 1);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single writes from the table, ptr wraps to 0 after channel 7.
    for (int i = 0; i < 4; i++) begin
      req_data[12*vecs[i].ch +: 12] = vecs[i].data;
      exp_q.push_back(vecs[i].word);
      req[vecs[i].ch] = 1'b1;
      wait_ack(vecs[i].ch);
      repeat (8) @(negedge clk);
    end

    // All channels requesting continuously.
    for (int i = 0; i < N_CH; i++) begin
      d8[i] = 12'(i * 12'h111) ^ 12'h05A;
      req_data[12*i +: 12] = d8[i];
    end
    for (int k = 0; k < 9; k++) exp_q.push_back({4'(k % N_CH), d8[k % N_CH]});
    base = frames;
    req  = '1;
    n    = 0;
    while (frames < base + 9 && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    req = '0;
    chk("all8_frames", frames - base, 9);
    chk("frame_period", last_period, 32 * DIV + GAP + 1);
    repeat (8) @(negedge clk);

    // Fairness across the wrap: after 6, channel 7 precedes channel 2.
    req_data[6*12 +: 12] = 12'h666;
    exp_q.push_back(16'h6666);
    req[6] = 1'b1;
    wait_ack(6);
    repeat (8) @(negedge clk);
    req_data[2*12 +: 12] = 12'h222;
    req_data[7*12 +: 12] = 12'h777;
    exp_q.push_back(16'h7777);
    exp_q.push_back(16'h2222);
    req[2] = 1'b1; req[7] = 1'b1;
    wait_ack(7);
    wait_ack(2);
    repeat (8) @(negedge clk);

    // Data changes after grant must not disturb the frame.
    req_data[1*12 +: 12] = 12'h123;
    exp_q.push_back(16'h1123);
    req[1] = 1'b1;
    n = 0;
    while (nsync && n < 100) begin
      @(negedge clk); n++;
    end
    chk("chg_in_frame", nsync, 0);
    repeat (4) @(negedge clk);
    req_data[1*12 +: 12] = 12'hFFF;
    wait_ack(1);
    repeat (8) @(negedge clk);

    // Reset during bit 9, then regrant of the still-pending request.
    req_data[0 +: 12] = 12'h0A5;
    req[0] = 1'b1;
    acks_before = ack_total;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(in_frame && bits >= 7) && n < 400);
    chk("pre_rst_nsync", nsync, 0);
    aresetn = 1'b0;
    #1;
    chk("midrst_nsync", nsync, 1);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_din", din, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    repeat (3) @(negedge clk);
    chk("no_ack_cut_frame", ack_total, acks_before);
    exp_q.push_back(16'h00A5);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_edge1_nsync", nsync, 1);
    @(posedge clk); #1;
    chk("rel_edge2_nsync", nsync, 1);
    @(posedge clk); #1;
    chk("rel_edge3_nsync", nsync, 0);
    chk("rel_edge3_busy", busy, 1);
    wait_ack(0);
    repeat (8) @(negedge clk);

    // Minimum configuration, back-to-back frames.
    req_data_b = {12'hC0F, 12'h321};
    base  = frames_b;
    req_b = '1;
    n     = 0;
    while (frames_b < base + 4 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    req_b = '0;
    chk("min_frames", frames_b - base, 4);
    chk("min_period", period_b, 34);
    chk("min_low_len", last_low_b, 32);
    chk("min_word", last_word_b, 16'h1C0F);
    chk("min_ack", last_ack_b, 2'b10);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("ack_total", ack_total, frames);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
